// File: rtl/seg7_readback_monitor_pkg.sv
// Shared constants for the 7-segment readback path: glyph table, blank code, FSM states.
// Latency: n/a (constants only).
// Backpressure: n/a.
package seg7_readback_pkg;

  // Active-low glyphs, bit order {g,f,e,d,c,b,a}
  localparam logic [6:0] SEG_0 = 7'b1000000;
  localparam logic [6:0] SEG_1 = 7'b1111001;
  localparam logic [6:0] SEG_2 = 7'b0100100;
  localparam logic [6:0] SEG_3 = 7'b0110000;
  localparam logic [6:0] SEG_4 = 7'b0011001;
  localparam logic [6:0] SEG_5 = 7'b0010010;
  localparam logic [6:0] SEG_6 = 7'b0000010;
  localparam logic [6:0] SEG_7 = 7'b1111000;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0010000;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b0000011;
  localparam logic [6:0] SEG_C = 7'b1000110;
  localparam logic [6:0] SEG_D = 7'b0100001;
  localparam logic [6:0] SEG_E = 7'b0000110;
  localparam logic [6:0] SEG_F = 7'b0001110;

  // All segments off
  localparam logic [6:0] SEG_BLANK = 7'h7F;

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_SEND = 1'b1;

  typedef enum logic [0:0] {
    IDLE = ST_IDLE,
    SEND = ST_SEND
  } state_e;

endpackage

// File: rtl/seg7_readback_monitor_if.sv
// Event stream carrying one decoded digit change per transfer.
// Latency: n/a (wires only).
// Backpressure: valid/ready; master holds all fields stable while valid && !ready.
interface seg7_readback_monitor_if #(
  parameter int DIG_W = 3
);
  logic             ev_valid;
  logic             ev_ready;
  logic [DIG_W-1:0] ev_digit;
  logic [3:0]       ev_value;
  logic             ev_legal;
  logic             ev_blank;

  modport master (
    output ev_valid, ev_digit, ev_value, ev_legal, ev_blank,
    input  ev_ready
  );

  modport slave (
    input  ev_valid, ev_digit, ev_value, ev_legal, ev_blank,
    output ev_ready
  );
endinterface

// File: rtl/seg7_readback_monitor_seg7_to_hex.sv
// Decodes one active-low 7-segment pattern back to its hex value with legal/blank flags.
// Latency: combinational.
// Backpressure: none.
module seg7_to_hex
  import seg7_readback_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] value,
  output logic       legal,
  output logic       blank
);

  // Table lookup; anything off-table reports value 0 with legal cleared
  always_comb begin
    value = 4'h0;
    legal = 1'b1;
    blank = 1'b0;
    case (seg)
      SEG_0: value = 4'h0;
      SEG_1: value = 4'h1;
      SEG_2: value = 4'h2;
      SEG_3: value = 4'h3;
      SEG_4: value = 4'h4;
      SEG_5: value = 4'h5;
      SEG_6: value = 4'h6;
      SEG_7: value = 4'h7;
      SEG_8: value = 4'h8;
      SEG_9: value = 4'h9;
      SEG_A: value = 4'hA;
      SEG_B: value = 4'hB;
      SEG_C: value = 4'hC;
      SEG_D: value = 4'hD;
      SEG_E: value = 4'hE;
      SEG_F: value = 4'hF;
      SEG_BLANK: begin
        legal = 1'b0;
        blank = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

endmodule

// File: rtl/seg7_readback_monitor.sv
// Resyncs, debounces and decodes six 7-seg digits; each committed change becomes one stream event.
// Latency: commit STABLE_CYCLES+1 edges after first hex_q sample, event valid one edge later.
// Backpressure: ev_* held while ready low; further commits coalesce per digit. SEG7_READBACK_DROP_CNT_EN adds drop_cnt.
module seg7_readback_monitor
  import seg7_readback_pkg::*;
#(
  parameter int NUM_DIGITS    = 6,
  parameter int STABLE_CYCLES = 4,
  parameter int DIG_W         = 3
)(
  input  logic                    CLOCK_50,
  input  logic                    RESET,
  input  logic [7*NUM_DIGITS-1:0] hex_in,
  seg7_readback_monitor_if.master ev,
  output logic [4*NUM_DIGITS-1:0] digits_out,
  output logic [NUM_DIGITS-1:0]   blank_mask
`ifdef SEG7_READBACK_DROP_CNT_EN
  ,
  output logic [7:0]              drop_cnt
`endif
);

  localparam int             CNT_W   = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [DIG_W-1:0] DIG_LAST = DIG_W'(NUM_DIGITS - 1);

  logic [NUM_DIGITS-1:0][6:0]       hex_q, hex_d;
  logic [NUM_DIGITS-1:0][6:0]       cand_q, cand_d;
  logic [NUM_DIGITS-1:0][6:0]       committed_q, committed_d;
  logic [NUM_DIGITS-1:0][CNT_W-1:0] cnt_q, cnt_d;
  logic [NUM_DIGITS-1:0]            commit_hit;
  logic [NUM_DIGITS-1:0]            pending_q, pending_d;
  logic [DIG_W-1:0]                 rr_ptr_q, rr_ptr_d;
  state_e                           state_q, state_d;

  logic             ev_valid_q, ev_valid_d;
  logic [DIG_W-1:0] ev_digit_q, ev_digit_d;
  logic [3:0]       ev_value_q, ev_value_d;
  logic             ev_legal_q, ev_legal_d;
  logic             ev_blank_q, ev_blank_d;

  logic             sel_found;
  logic [DIG_W-1:0] sel, sel_try;
  int               sel_idx;
  logic [3:0]       sel_value;
  logic             sel_legal, sel_blank;
  logic [NUM_DIGITS-1:0] dig_legal_unused;

  // Per-digit stability filter: restart on change, saturate the counter, commit once stable
  always_comb begin
    hex_d       = hex_in;
    cand_d      = cand_q;
    cnt_d       = cnt_q;
    committed_d = committed_q;
    commit_hit  = '0;
    for (int d = 0; d < NUM_DIGITS; d++) begin
      if (hex_q[d] != cand_q[d]) begin
        cand_d[d] = hex_q[d];
        cnt_d[d]  = '0;
      end else if (cnt_q[d] < CNT_MAX) begin
        cnt_d[d] = cnt_q[d] + CNT_W'(1);
      end else if (cand_q[d] != committed_q[d]) begin
        committed_d[d] = cand_q[d];
        commit_hit[d]  = 1'b1;
      end
    end
  end

  // Round-robin pick: first pending digit at or above rr_ptr, wrapping
  always_comb begin
    sel_found = 1'b0;
    sel       = '0;
    sel_idx   = 0;
    sel_try   = '0;
    for (int i = 0; i < NUM_DIGITS; i++) begin
      sel_idx = (int'(rr_ptr_q) + i) % NUM_DIGITS;
      sel_try = DIG_W'(sel_idx);
      if (!sel_found && pending_q[sel_try]) begin
        sel_found = 1'b1;
        sel       = sel_try;
      end
    end
  end

  seg7_to_hex u_ev_dec (
    .seg   (committed_q[sel]),
    .value (sel_value),
    .legal (sel_legal),
    .blank (sel_blank)
  );

  // Output FSM; commit sets are applied after the load clear so a same-cycle commit stays pending
  always_comb begin
    state_d    = state_q;
    pending_d  = pending_q;
    rr_ptr_d   = rr_ptr_q;
    ev_valid_d = ev_valid_q;
    ev_digit_d = ev_digit_q;
    ev_value_d = ev_value_q;
    ev_legal_d = ev_legal_q;
    ev_blank_d = ev_blank_q;
    case (state_q)
      IDLE: begin
        if (sel_found) begin
          ev_valid_d     = 1'b1;
          ev_digit_d     = sel;
          ev_value_d     = sel_value;
          ev_legal_d     = sel_legal;
          ev_blank_d     = sel_blank;
          pending_d[sel] = 1'b0;
          state_d        = SEND;
        end
      end
      SEND: begin
        if (ev.ev_ready) begin
          ev_valid_d = 1'b0;
          rr_ptr_d   = (ev_digit_q == DIG_LAST) ? '0 : ev_digit_q + DIG_W'(1);
          state_d    = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    pending_d = pending_d | commit_hit;
  end

  // State registers with synchronous reset to the all-blank, idle condition
  always_ff @(posedge CLOCK_50) begin
    if (RESET) begin
      hex_q       <= {NUM_DIGITS{SEG_BLANK}};
      cand_q      <= {NUM_DIGITS{SEG_BLANK}};
      committed_q <= {NUM_DIGITS{SEG_BLANK}};
      cnt_q       <= '0;
      pending_q   <= '0;
      rr_ptr_q    <= '0;
      state_q     <= IDLE;
      ev_valid_q  <= 1'b0;
      ev_digit_q  <= '0;
      ev_value_q  <= '0;
      ev_legal_q  <= 1'b0;
      ev_blank_q  <= 1'b0;
    end else begin
      hex_q       <= hex_d;
      cand_q      <= cand_d;
      committed_q <= committed_d;
      cnt_q       <= cnt_d;
      pending_q   <= pending_d;
      rr_ptr_q    <= rr_ptr_d;
      state_q     <= state_d;
      ev_valid_q  <= ev_valid_d;
      ev_digit_q  <= ev_digit_d;
      ev_value_q  <= ev_value_d;
      ev_legal_q  <= ev_legal_d;
      ev_blank_q  <= ev_blank_d;
    end
  end

  assign ev.ev_valid = ev_valid_q;
  assign ev.ev_digit = ev_digit_q;
  assign ev.ev_value = ev_value_q;
  assign ev.ev_legal = ev_legal_q;
  assign ev.ev_blank = ev_blank_q;

  for (genvar d = 0; d < NUM_DIGITS; d++) begin : g_dig
    seg7_to_hex u_dec (
      .seg   (committed_q[d]),
      .value (digits_out[4*d +: 4]),
      .legal (dig_legal_unused[d]),
      .blank (blank_mask[d])
    );
  end

`ifdef SEG7_READBACK_DROP_CNT_EN
  logic [7:0] drop_cnt_q, drop_cnt_d;
  logic [8:0] drop_sum;

  // Count commits that overwrite a not-yet-reported value, saturating at 255
  always_comb begin
    drop_sum   = 9'(drop_cnt_q) + 9'($countones(commit_hit & pending_q));
    drop_cnt_d = (drop_sum > 9'd255) ? 8'hFF : drop_sum[7:0];
  end

  // Drop counter register
  always_ff @(posedge CLOCK_50) begin
    if (RESET) drop_cnt_q <= '0;
    else       drop_cnt_q <= drop_cnt_d;
  end

  assign drop_cnt = drop_cnt_q;
`endif

endmodule

// File: tb/tb_seg7_readback_monitor.sv
// Directed bench for seg7_readback_monitor: decode table sweep plus multi-cycle corner sequences.
// Latency: n/a.
// Backpressure: driven by the bench through ev_ready.
module tb_seg7_readback_monitor;

  logic        CLOCK_50 = 1'b0;
  logic        RESET;
  logic [41:0] hex_in;
  logic [23:0] digits_out;
  logic [5:0]  blank_mask;
`ifdef SEG7_READBACK_DROP_CNT_EN
  logic [7:0]  drop_cnt;
`endif

  always #10 CLOCK_50 = ~CLOCK_50;

  seg7_readback_monitor_if #(.DIG_W(3)) ev_if ();

  seg7_readback_monitor #(
    .NUM_DIGITS    (6),
    .STABLE_CYCLES (4),
    .DIG_W         (3)
  ) dut (
    .CLOCK_50   (CLOCK_50),
    .RESET      (RESET),
    .hex_in     (hex_in),
    .ev         (ev_if),
    .digits_out (digits_out),
    .blank_mask (blank_mask)
`ifdef SEG7_READBACK_DROP_CNT_EN
    ,
    .drop_cnt   (drop_cnt)
`endif
  );

  typedef struct {
    logic [6:0] seg;
    logic [3:0] val;
    logic       legal;
    logic       blank;
  } vec_t;

  vec_t tbl [19];
  int   checks   = 0;
  int   failures = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge CLOCK_50);
    #1;
  endtask

  task automatic set_dig(input int d, input logic [6:0] pat);
    hex_in[7*d +: 7] = pat;
  endtask

  task automatic do_reset();
    RESET          = 1'b1;
    hex_in         = {6{7'h7F}};
    ev_if.ev_ready = 1'b0;
    step();
    step();
    RESET = 1'b0;
  endtask

  task automatic wait_valid(input int max_cyc, input string nm);
    int n;
    n = 0;
    while (ev_if.ev_valid !== 1'b1 && n < max_cyc) begin
      step();
      n++;
    end
    chk(nm, ev_if.ev_valid, 1);
  endtask

  task automatic accept();
    ev_if.ev_ready = 1'b1;
    step();
    ev_if.ev_ready = 1'b0;
  endtask

  task automatic expect_quiet(input int cyc, input string nm);
    int seen;
    seen = 0;
    repeat (cyc) begin
      step();
      if (ev_if.ev_valid === 1'b1) seen++;
    end
    chk(nm, seen, 0);
  endtask

  initial begin
    int n;
    int captured;
    int unstable;
    logic [9:0] snap;

    tbl[0]  = '{7'b1000000, 4'h0, 1'b1, 1'b0};
    tbl[1]  = '{7'b1111001, 4'h1, 1'b1, 1'b0};
    tbl[2]  = '{7'b0100100, 4'h2, 1'b1, 1'b0};
    tbl[3]  = '{7'b0110000, 4'h3, 1'b1, 1'b0};
    tbl[4]  = '{7'b0011001, 4'h4, 1'b1, 1'b0};
    tbl[5]  = '{7'b0010010, 4'h5, 1'b1, 1'b0};
    tbl[6]  = '{7'b0000010, 4'h6, 1'b1, 1'b0};
    tbl[7]  = '{7'b1111000, 4'h7, 1'b1, 1'b0};
    tbl[8]  = '{7'b0000000, 4'h8, 1'b1, 1'b0};
    tbl[9]  = '{7'b0010000, 4'h9, 1'b1, 1'b0};
    tbl[10] = '{7'b0001000, 4'hA, 1'b1, 1'b0};
    tbl[11] = '{7'b0000011, 4'hB, 1'b1, 1'b0};
    tbl[12] = '{7'b1000110, 4'hC, 1'b1, 1'b0};
    tbl[13] = '{7'b0100001, 4'hD, 1'b1, 1'b0};
    tbl[14] = '{7'b0000110, 4'hE, 1'b1, 1'b0};
    tbl[15] = '{7'b0001110, 4'hF, 1'b1, 1'b0};
    tbl[16] = '{7'b1111111, 4'h0, 1'b0, 1'b1};
    tbl[17] = '{7'b0101010, 4'h0, 1'b0, 1'b0};
    tbl[18] = '{7'b1111110, 4'h0, 1'b0, 1'b0};

    // Reset state
    do_reset();
    chk("rst_ev_valid", ev_if.ev_valid, 0);
    chk("rst_ev_digit", ev_if.ev_digit, 0);
    chk("rst_ev_value", ev_if.ev_value, 0);
    chk("rst_ev_legal", ev_if.ev_legal, 0);
    chk("rst_ev_blank", ev_if.ev_blank, 0);
    chk("rst_digits_out", digits_out, 0);
    chk("rst_blank_mask", blank_mask, 6'h3F);
`ifdef SEG7_READBACK_DROP_CNT_EN
    chk("rst_drop_cnt", drop_cnt, 0);
`endif

    // Blank hold with ready asserted: nothing to report
    ev_if.ev_ready = 1'b1;
    expect_quiet(50, "blank_hold_no_event");
    ev_if.ev_ready = 1'b0;
    chk("blank_hold_digits", digits_out, 0);
    chk("blank_hold_mask", blank_mask, 6'h3F);

    // Single change: capture edge E0, commit at E0+5, valid after E0+6 -> 7th edge after the drive
    set_dig(2, 7'b0100100);
    n = 0;
    while (ev_if.ev_valid !== 1'b1 && n < 20) begin
      step();
      n++;
    end
    chk("single_latency_edges", n, 7);
    chk("single_digit", ev_if.ev_digit, 2);
    chk("single_value", ev_if.ev_value, 2);
    chk("single_legal", ev_if.ev_legal, 1);
    chk("single_blank", ev_if.ev_blank, 0);
    accept();
    chk("single_valid_drop", ev_if.ev_valid, 0);
    chk("single_digits_out", digits_out[11:8], 2);
    chk("single_mask", blank_mask, 6'h3B);
    expect_quiet(10, "single_no_repeat");

    // Glitch: four hex_q samples is one short of committing
    set_dig(0, 7'b1111001);
    repeat (4) step();
    set_dig(0, 7'h7F);
    expect_quiet(15, "glitch_no_event");
    chk("glitch_digit0", digits_out[3:0], 0);
    chk("glitch_mask0", blank_mask[0], 1);

    // Decode sweep through the full datapath on digit 3
    do_reset();
    for (int i = 0; i < 19; i++) begin
      set_dig(3, tbl[i].seg);
      wait_valid(20, "tbl_valid");
      chk("tbl_digit", ev_if.ev_digit, 3);
      chk("tbl_value", ev_if.ev_value, tbl[i].val);
      chk("tbl_legal", ev_if.ev_legal, tbl[i].legal);
      chk("tbl_blank", ev_if.ev_blank, tbl[i].blank);
      accept();
      chk("tbl_digits_out", digits_out[15:12], tbl[i].val);
      chk("tbl_mask", blank_mask[3], tbl[i].blank);
    end

    // Simultaneous change on all digits under a 20-cycle stall
    do_reset();
    hex_in = {7'b0010010, 7'b0011001, 7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000};
    captured = 0;
    unstable = 0;
    snap = '0;
    repeat (20) begin
      step();
      if (ev_if.ev_valid === 1'b1) begin
        if (captured == 0) begin
          snap = {ev_if.ev_digit, ev_if.ev_value, ev_if.ev_legal, ev_if.ev_blank};
          captured = 1;
        end else if (snap !== {ev_if.ev_digit, ev_if.ev_value, ev_if.ev_legal, ev_if.ev_blank}) begin
          unstable = 1;
        end
      end
    end
    chk("stall_valid_seen", captured, 1);
    chk("stall_stable", unstable, 0);
    for (int k = 0; k < 6; k++) begin
      wait_valid(5, "multi_valid");
      chk("multi_digit", ev_if.ev_digit, k);
      chk("multi_value", ev_if.ev_value, k);
      chk("multi_legal", ev_if.ev_legal, 1);
      accept();
    end
    expect_quiet(10, "multi_no_extra");
    chk("multi_digits_out", digits_out, 24'h543210);

    // Coalescing: two digit-1 commits behind a stalled digit-0 event
    do_reset();
    set_dig(0, 7'b1111000);
    wait_valid(20, "coal_d0_valid");
    set_dig(1, 7'b0110000);
    repeat (10) step();
    set_dig(1, 7'b0011001);
    repeat (10) step();
    chk("coal_still_d0", ev_if.ev_digit, 0);
    chk("coal_d0_value", ev_if.ev_value, 7);
`ifdef SEG7_READBACK_DROP_CNT_EN
    chk("coal_drop_cnt", drop_cnt, 1);
`endif
    accept();
    wait_valid(5, "coal_d1_valid");
    chk("coal_d1_digit", ev_if.ev_digit, 1);
    chk("coal_d1_value", ev_if.ev_value, 4);
    accept();
    expect_quiet(15, "coal_single_d1");

    // Illegal pattern, then reset while the event is stalled
    do_reset();
    set_dig(4, 7'b0101010);
    wait_valid(20, "illegal_valid");
    chk("illegal_digit", ev_if.ev_digit, 4);
    chk("illegal_value", ev_if.ev_value, 0);
    chk("illegal_legal", ev_if.ev_legal, 0);
    chk("illegal_blank", ev_if.ev_blank, 0);
    chk("illegal_mask", blank_mask[4], 0);
    repeat (3) step();
    RESET  = 1'b1;
    hex_in = {6{7'h7F}};
    step();
    chk("midsend_reset_valid", ev_if.ev_valid, 0);
    RESET = 1'b0;
    expect_quiet(20, "midsend_no_replay");
    chk("midsend_mask", blank_mask, 6'h3F);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
